// File: rtl/dut_crc_mem_pkg.sv
// Shared CRC-8 (poly 0x07) helpers for the CRC-protected memory banks.
// The syndrome lookup is used only when CRC_CORRECT_EN is defined.
package dut_crc_mem_pkg;

  localparam logic [7:0]  CRC_POLY = 8'h07;
  localparam int unsigned CRC_W    = 8;
  localparam int unsigned MAX_W    = 32;

  typedef struct packed {
    logic       hit;
    logic [6:0] idx;  // codeword bit: 0..7 CRC bits, 8.. data bit (idx-8)
  } syn_loc_t;

  // MSB-first CRC over the low len bits of data; init 0, no reflection, no final XOR.
  function automatic logic [7:0] crc8(input logic [MAX_W-1:0] data, input int len);
    logic [7:0] crc;
    logic       fb;
    crc = '0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (i < len) begin
        fb  = crc[7] ^ data[i];
        crc = {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
      end
    end
    return crc;
  endfunction

  // Match a syndrome against every single-bit error pattern of a len-bit data word.
  function automatic syn_loc_t syn_to_bit(input logic [7:0] syn, input int len);
    syn_loc_t         loc;
    logic [MAX_W-1:0] e;
    logic [7:0]       pat;
    loc = '0;
    for (int k = 0; k < int'(MAX_W + CRC_W); k++) begin
      if (k < int'(CRC_W)) begin
        pat = 8'(1 << k);
      end else begin
        e = '0;
        e[k - int'(CRC_W)] = 1'b1;
        pat = crc8(e, len);
      end
      if ((k < len + int'(CRC_W)) && (syn != 8'h00) && (syn == pat)) begin
        loc.hit = 1'b1;
        loc.idx = 7'(k);
      end
    end
    return loc;
  endfunction

endpackage

// File: rtl/dut_crc_mem_bank.sv
// One CRC-protected single-port RAM bank with registered read data and error flags.
// Correction logic is present only when CRC_CORRECT_EN is defined.
module crc_mem_bank
  import dut_crc_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              err_detected,
  output logic              err_corrected
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned WordW = DATA_W + CRC_W;

  // Storage is deliberately not reset; only the valid bits are.
  logic [WordW-1:0]  mem_array [Depth];
  logic [Depth-1:0]  valid_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic              det_q, det_d, cor_q, cor_d;
  logic [MAX_W-1:0]  wr_ext, rd_ext;
  logic [WordW-1:0]  rd_word;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        wr_crc, syn;

  always_comb begin
    wr_ext = '0;
    wr_ext[DATA_W-1:0] = data_in;
    wr_crc = crc8(wr_ext, int'(DATA_W));
  end

  always_ff @(posedge clk) begin
    if (wr) mem_array[addr] <= {data_in, wr_crc};
  end

  always_comb begin
    rd_word = mem_array[addr];
    rd_data = rd_word[WordW-1:CRC_W];
    rd_ext  = '0;
    rd_ext[DATA_W-1:0] = rd_data;
    syn     = crc8(rd_ext, int'(DATA_W)) ^ rd_word[CRC_W-1:0];
  end

`ifdef CRC_CORRECT_EN
  syn_loc_t          loc;
  logic [DATA_W-1:0] fix_data;

  always_comb begin
    loc      = syn_to_bit(syn, int'(DATA_W));
    fix_data = rd_data;
    for (int j = 0; j < int'(DATA_W); j++) begin
      if (loc.idx == 7'(j + int'(CRC_W))) fix_data[j] = ~rd_data[j];
    end
  end
`endif

  always_comb begin
    data_d = '0;
    det_d  = 1'b0;
    cor_d  = 1'b0;
    if (wr) begin
      data_d = data_in;
    end else if (valid_q[addr]) begin
      data_d = rd_data;
      det_d  = (syn != 8'h00);
`ifdef CRC_CORRECT_EN
      if (loc.hit) begin
        cor_d  = 1'b1;
        data_d = fix_data;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      det_q   <= 1'b0;
      cor_q   <= 1'b0;
    end else begin
      if (wr) valid_q[addr] <= 1'b1;
      data_q <= data_d;
      det_q  <= det_d;
      cor_q  <= cor_d;
    end
  end

  assign data_out      = data_q;
  assign err_detected  = det_q;
  assign err_corrected = cor_q;

endmodule

// File: rtl/dut_crc_mem.sv
// Two independent CRC-protected RAMs: MEM1 (256 x 32) and MEM2 (256 x 8).
// Build with CRC_CORRECT_EN defined to enable single-bit correction.
module dut_crc_mem (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem1_wr,
  input  logic [7:0]  mem1_addr,
  input  logic [31:0] mem1_data_in,
  output logic [31:0] mem1_data_out,
  output logic        mem1_err_detected,
  output logic        mem1_err_corrected,
  input  logic        mem2_wr,
  input  logic [7:0]  mem2_addr,
  input  logic [7:0]  mem2_data_in,
  output logic [7:0]  mem2_data_out,
  output logic        mem2_err_detected,
  output logic        mem2_err_corrected
);

  crc_mem_bank #(
    .DATA_W(32),
    .ADDR_W(8)
  ) u_mem1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (mem1_wr),
    .addr         (mem1_addr),
    .data_in      (mem1_data_in),
    .data_out     (mem1_data_out),
    .err_detected (mem1_err_detected),
    .err_corrected(mem1_err_corrected)
  );

  crc_mem_bank #(
    .DATA_W(8),
    .ADDR_W(8)
  ) u_mem2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (mem2_wr),
    .addr         (mem2_addr),
    .data_in      (mem2_data_in),
    .data_out     (mem2_data_out),
    .err_detected (mem2_err_detected),
    .err_corrected(mem2_err_corrected)
  );

endmodule

// File: tb/tb_dut_crc_mem.sv
// Scoreboard bench for dut_crc_mem; expected values follow CRC_CORRECT_EN when defined.
module tb_dut_crc_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem1_wr;
  logic [7:0]  mem1_addr;
  logic [31:0] mem1_data_in;
  logic [31:0] mem1_data_out;
  logic        mem1_err_detected;
  logic        mem1_err_corrected;
  logic        mem2_wr;
  logic [7:0]  mem2_addr;
  logic [7:0]  mem2_data_in;
  logic [7:0]  mem2_data_out;
  logic        mem2_err_detected;
  logic        mem2_err_corrected;

  dut_crc_mem dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem1_wr           (mem1_wr),
    .mem1_addr         (mem1_addr),
    .mem1_data_in      (mem1_data_in),
    .mem1_data_out     (mem1_data_out),
    .mem1_err_detected (mem1_err_detected),
    .mem1_err_corrected(mem1_err_corrected),
    .mem2_wr           (mem2_wr),
    .mem2_addr         (mem2_addr),
    .mem2_data_in      (mem2_data_in),
    .mem2_data_out     (mem2_data_out),
    .mem2_err_detected (mem2_err_detected),
    .mem2_err_corrected(mem2_err_corrected)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        det;
    logic        cor;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] m1 [256];
  logic [7:0]  m2 [256];
  logic        v1 [256];
  logic        v2 [256];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model1(input logic w, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e = '0;
    if (w) begin
      m1[a] = d;
      v1[a] = 1'b1;
      e.data = d;
    end else if (v1[a]) begin
      e.data = m1[a];
    end
    return e;
  endfunction

  function automatic exp_t model2(input logic w, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e = '0;
    if (w) begin
      m2[a] = d;
      v2[a] = 1'b1;
      e.data = {24'h0, d};
    end else if (v2[a]) begin
      e.data = {24'h0, m2[a]};
    end
    return e;
  endfunction

  // Drive one cycle on both banks, queue expectations, then compare after the edge.
  task automatic drive_exp(input logic w1, input logic [7:0] a1, input logic [31:0] d1,
                           input exp_t e1, input logic w2, input logic [7:0] a2,
                           input logic [7:0] d2, input exp_t e2);
    exp_t g;
    mem1_wr = w1; mem1_addr = a1; mem1_data_in = d1;
    mem2_wr = w2; mem2_addr = a2; mem2_data_in = d2;
    q1.push_back(e1);
    q2.push_back(e2);
    @(posedge clk);
    #1;
    g = q1.pop_front();
    check_eq($sformatf("mem1_data a=%0h", a1), mem1_data_out, g.data);
    check_eq($sformatf("mem1_det a=%0h", a1), {31'h0, mem1_err_detected}, {31'h0, g.det});
    check_eq($sformatf("mem1_cor a=%0h", a1), {31'h0, mem1_err_corrected}, {31'h0, g.cor});
    g = q2.pop_front();
    check_eq($sformatf("mem2_data a=%0h", a2), {24'h0, mem2_data_out}, g.data);
    check_eq($sformatf("mem2_det a=%0h", a2), {31'h0, mem2_err_detected}, {31'h0, g.det});
    check_eq($sformatf("mem2_cor a=%0h", a2), {31'h0, mem2_err_corrected}, {31'h0, g.cor});
  endtask

  task automatic drive(input logic w1, input logic [7:0] a1, input logic [31:0] d1,
                       input logic w2, input logic [7:0] a2, input logic [7:0] d2);
    exp_t e1, e2;
    e1 = model1(w1, a1, d1);
    e2 = model2(w2, a2, d2);
    drive_exp(w1, a1, d1, e1, w2, a2, d2, e2);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, " mem1_data"}, mem1_data_out, 32'h0);
    check_eq({tag, " mem2_data"}, {24'h0, mem2_data_out}, 32'h0);
    check_eq({tag, " flags"}, {28'h0, mem1_err_detected, mem1_err_corrected,
                               mem2_err_detected, mem2_err_corrected}, 32'h0);
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    logic [39:0] w1;
    logic [15:0] w2;
    exp_t        e1, e2;

    for (int i = 0; i < 256; i++) begin
      v1[i] = 1'b0;
      v2[i] = 1'b0;
      m1[i] = '0;
      m2[i] = '0;
    end
    rst_n = 1'b0;
    mem1_wr = 1'b0; mem1_addr = '0; mem1_data_in = '0;
    mem2_wr = 1'b0; mem2_addr = '0; mem2_data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unwritten address reads zero on both banks.
    drive(1'b0, 8'h05, 32'h0, 1'b0, 8'h05, 8'h0);

    // MEM1 write burst while MEM2 reads unwritten addresses.
    for (int i = 1; i <= 50; i++)
      drive(1'b1, 8'(i), 32'(i * 32'h1111), 1'b0, 8'(i + 100), 8'h0);
    // MEM1 read-back while MEM2 writes concurrently.
    for (int i = 1; i <= 50; i++)
      drive(1'b0, 8'(i), 32'h0, 1'b1, 8'(i + 100), 8'(i * 7));

    drive(1'b0, 8'h00, 32'h0, 1'b1, 8'h03, 8'h05);
    drive(1'b0, 8'h00, 32'h0, 1'b0, 8'h03, 8'h0);

    // Single-bit fault in MEM1 data bit 4 at address 1.
    w1 = dut.u_mem1.mem_array[1];
    w1[12] = ~w1[12];
    dut.u_mem1.mem_array[1] = w1;
    // Double-bit fault in MEM2 data bits 0 and 1 at address 3.
    w2 = dut.u_mem2.mem_array[3];
    w2[9:8] = ~w2[9:8];
    dut.u_mem2.mem_array[3] = w2;

`ifdef CRC_CORRECT_EN
    e1 = '{data: 32'h0000_1111, det: 1'b1, cor: 1'b1};
`else
    e1 = '{data: 32'h0000_1101, det: 1'b1, cor: 1'b0};
`endif
    e2 = '{data: 32'h0000_0006, det: 1'b1, cor: 1'b0};
    drive_exp(1'b0, 8'h01, 32'h0, e1, 1'b0, 8'h03, 8'h0, e2);
    // Clean neighbours drop the flags; faults persist on re-read.
    drive(1'b0, 8'h02, 32'h0, 1'b0, 8'h65, 8'h0);
    drive_exp(1'b0, 8'h01, 32'h0, e1, 1'b0, 8'h03, 8'h0, e2);
    // Rewrite heals the entries.
    drive(1'b1, 8'h01, 32'hDEAD_BEEF, 1'b1, 8'h03, 8'hA5);
    drive(1'b0, 8'h01, 32'h0, 1'b0, 8'h03, 8'h0);

    // Reset asserted in the middle of a read burst.
    drive(1'b0, 8'h10, 32'h0, 1'b0, 8'h66, 8'h0);
    mem1_wr = 1'b0; mem1_addr = 8'h11;
    mem2_wr = 1'b0; mem2_addr = 8'h67;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    #1;
    check_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      v1[i] = 1'b0;
      v2[i] = 1'b0;
    end
    drive(1'b0, 8'h11, 32'h0, 1'b0, 8'h67, 8'h0);
    drive(1'b0, 8'h01, 32'h0, 1'b0, 8'h03, 8'h0);
    drive(1'b1, 8'hFF, 32'h1234_5678, 1'b1, 8'hFF, 8'h3C);
    drive(1'b0, 8'hFF, 32'h0, 1'b0, 8'hFF, 8'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
